// File: rtl/i2c_slave_control.sv
// Bit-level I2C slave engine: synchronizes SCL/SDA, detects START/STOP, receives the
// address and moves data bytes to/from the attached memory via Enable/RorW handshake.
module i2c_slave_control #(
    parameter int unsigned ADDRESSLENGTH = 7,
    parameter int unsigned SYNCSTAGES    = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     SCL,
    input  logic                     SDA,
    output logic                     SDA_oe,
    output logic                     Enable,
    output logic                     RorW,
    output logic [ADDRESSLENGTH-1:0] DirectionBuffer,
    output logic [7:0]               InputBuffer,
    input  logic [7:0]               OutputBuffer,
    input  logic                     AddressFound,
    output logic                     Busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    logic [SYNCSTAGES-1:0] scl_sync_q, sda_sync_q;
    logic                  scl_hist_q, sda_hist_q;
    logic                  scl_s, sda_s, scl_rise, scl_fall, start_p, stop_p;

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [7:0]                 shift_q, shift_d, inbuf_q, inbuf_d, rx_byte;
    logic [ADDRESSLENGTH-1:0]   dir_q, dir_d;
    logic                       oe_q, oe_d, en_q, en_d, rorw_q, rorw_d, busy_q, busy_d;
    logic                       first_q, first_d;

    // Synchronizers reset to the idle-high bus level so release of reset makes no edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNCSTAGES-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SYNCSTAGES-2:0], SDA};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNCSTAGES-1];
    assign sda_s    = sda_sync_q[SYNCSTAGES-1];
    assign scl_rise = scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s & scl_hist_q;
    assign start_p  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_p   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign rx_byte  = {shift_q[6:0], sda_s};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            inbuf_q <= '0;
            dir_q   <= '0;
            oe_q    <= 1'b0;
            en_q    <= 1'b0;
            rorw_q  <= 1'b0;
            busy_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            inbuf_q <= inbuf_d;
            dir_q   <= dir_d;
            oe_q    <= oe_d;
            en_q    <= en_d;
            rorw_q  <= rorw_d;
            busy_q  <= busy_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        inbuf_d = inbuf_q;
        dir_d   = dir_q;
        oe_d    = oe_q;
        rorw_d  = rorw_q;
        busy_d  = busy_q;
        en_d    = 1'b0;
        first_d = 1'b0;
        if (stop_p) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_p) begin
            state_d = S_ADDR;
            oe_d    = 1'b0;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: oe_d = 1'b0;
                S_ADDR: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            dir_d  = rx_byte[7:1];
                            rorw_d = ~sda_s;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        oe_d    = AddressFound;
                        state_d = AddressFound ? S_ADDR_ACK : S_WAIT_STOP;
                        first_d = AddressFound;
                    end
                end
                S_ADDR_ACK: begin
                    // Read: fetch the first byte early so OutputBuffer is settled by the ACK falling edge
                    en_d = first_q & ~rorw_q;
                    if (scl_fall) begin
                        if (rorw_q) begin
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = S_WR_DATA;
                        end else begin
                            shift_d = OutputBuffer;
                            oe_d    = ~OutputBuffer[7];
                            cnt_d   = 4'd1;
                            state_d = S_RD_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) inbuf_d = rx_byte;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        en_d    = 1'b1;
                        oe_d    = 1'b1;
                        state_d = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = S_RD_ACK;
                        end else begin
                            oe_d    = ~shift_q[6];
                            shift_d = {shift_q[6:0], 1'b0};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = S_WAIT_STOP;
                        else       en_d    = 1'b1;
                    end else if (scl_fall) begin
                        shift_d = OutputBuffer;
                        oe_d    = ~OutputBuffer[7];
                        cnt_d   = 4'd1;
                        state_d = S_RD_DATA;
                    end
                end
                S_WAIT_STOP: oe_d = 1'b0;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign SDA_oe          = oe_q;
    assign Enable          = en_q;
    assign RorW            = rorw_q;
    assign DirectionBuffer = dir_q;
    assign InputBuffer     = inbuf_q;
    assign Busy            = busy_q;

endmodule

// File: doc/i2c_slave_control.md
# i2c_slave_control

Bit-level I2C slave engine that sits directly upstream of `I2C_SLAVE_MEMORY`. It oversamples SCL/SDA on the system clock, detects START/STOP, and shifts in the address byte, presenting it on `DirectionBuffer`. It ACKs only when the memory reports `AddressFound`. It then moves data bytes between the bus and the memory through the `Enable`/`RorW`/`InputBuffer`/`OutputBuffer` handshake, driving SDA open-drain for ACK and read data.

## Interface
- `ADDRESSLENGTH`, 7: slave address width; must equal the memory's `ADDRESSLENGTH`; only 7 is supported.
- `SYNCSTAGES`, 2: flip-flop stages in the SCL and SDA synchronizers; must be ≥2.

Ports:
- `Clk` in 1: system clock. All logic is on its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `SCL` in 1: raw bus clock.
- `SDA` in 1: raw bus data, read back.
- `SDA_oe` out 1: 1 pulls SDA low, 0 releases it.
- `Enable` out 1: single-cycle transfer strobe to memory.
- `RorW` out 1: 1 = master writes to slave, 0 = master reads; equals inverted I2C R/W bit.
- `DirectionBuffer` out ADDRESSLENGTH: address received from the master.
- `InputBuffer` out 8: byte received from the master, for memory.
- `OutputBuffer` in 8: byte from memory, for transmission.
- `AddressFound` in 1: memory's address-match flag, combinational from `DirectionBuffer`.
- `Busy` out 1: high from START until STOP or reset.

## Operation
- **Synchronizers:** SCL/SDA pass through `SYNCSTAGES` flops plus one history flop. `sclRise`, `sclFall`, `start`, `stop` are single-cycle pulses.
  - `start`: synchronized SDA falls while SCL is high.
  - `stop`: synchronized SDA rises while SCL is high.
- **Bit order:** MSB first. SDA is sampled on `sclRise`. `SDA_oe` changes only on the `sclFall` cycle.
- **State machine:** IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- **IDLE:** `SDA_oe`=0. On `start`: `Busy`=1, bit counter=0, go to ADDR.
- **ADDR:** shift 8 bits.
  - On the 8th `sclRise`: `DirectionBuffer` <= bits[7:1] and `RorW` <= ~bit[0], both in the same cycle.
  - On the next `sclFall`: if `AddressFound`=1, set `SDA_oe`=1 and go to ADDR_ACK; otherwise go to WAIT_STOP with `SDA_oe`=0 (NACK).
- **ADDR_ACK:** if `RorW`=0, pulse `Enable` in the cycle after entry; `OutputBuffer` is valid one cycle after that. On `sclFall` ending the ACK bit:
  - Write (`RorW`=1): `SDA_oe`=0, go to WR_DATA.
  - Read (`RorW`=0): load the shift register from `OutputBuffer`, `SDA_oe`=~bit7, go to RD_DATA.
- **WR_DATA:** shift 8 bits. On the 8th `sclRise`, `InputBuffer` <= the assembled byte. On the next `sclFall`: `Enable`=1 for exactly one cycle, `SDA_oe`=1, go to WR_ACK.
- **WR_ACK:** on `sclFall`, `SDA_oe`=0, go to WR_DATA.
- **RD_DATA:** on each `sclFall`, drive the next bit as `SDA_oe`=~bit. After the 8th bit's `sclFall`, `SDA_oe`=0 and go to RD_ACK.
- **RD_ACK:** sample SDA on `sclRise`.
  - 0 (master ACK): pulse `Enable` in that cycle. On the next `sclFall`, load from `OutputBuffer`, drive MSB, go to RD_DATA.
  - 1 (master NACK): go to WAIT_STOP.
- **WAIT_STOP:** `SDA_oe`=0; ignores bus bits.
- **START/STOP override:**
  - `start` in any non-IDLE state (repeated START): `SDA_oe`=0, counter=0, go to ADDR. `DirectionBuffer` is unchanged until the new address completes.
  - `stop` in any state: `SDA_oe`=0, `Busy`=0, go to IDLE. A partial byte is discarded with no `Enable`.
  - If `start` and `stop` fire in the same cycle, `stop` wins.
- **Enable:** never high for two consecutive cycles, and never asserted while `RorW` changes.
- **Memory counter:** byte indexing is owned by the memory. Its counter resets only on a `DirectionBuffer` change.

## Timing
- **Reset values:** `SDA_oe`=0, `Enable`=0, `RorW`=0, `DirectionBuffer`=0, `InputBuffer`=0, `Busy`=0, state IDLE.
- **Reset mid-operation:** `SDA_oe` releases immediately (asynchronous).
- **Edge latency:** bus edge to internal pulse = `SYNCSTAGES`+1 cycles. `SDA_oe` change = 1 cycle after the `sclFall` pulse.
- **Bus constraint:** SCL high and low phases must each be ≥ `SYNCSTAGES`+4 `Clk` cycles.
  - Guarantees `AddressFound` settles before the ACK decision.
  - Guarantees `OutputBuffer` is valid before it is loaded.
- **Write data:** `InputBuffer` is stable from the 8th `sclRise` until the next byte's 8th `sclRise`, so it covers the `Enable` cycle.

## Test plan
- **Reset check:** after reset, all outputs at reset values; toggle SCL with no START -> `Busy`=0, `SDA_oe`=0, no `Enable`.
- **Matched write:** `AddressFound` modelled true for 0x48. START, 0x90, 0xA5, 0x3C, STOP -> `DirectionBuffer`=0x48, `RorW`=1, ACK on all 3 bytes, exactly 2 `Enable` pulses with `InputBuffer`=0xA5 then 0x3C, `Busy`=0 after STOP.
- **Read:** START, 0x91; memory returns 0x5A then 0xC3; master ACK then NACK -> SDA shows 0x5A, 0xC3; 2 `Enable` pulses; `RorW`=0; WAIT_STOP until STOP.
- **Address mismatch:** START, 0x22 -> NACK, `SDA_oe` stays 0 through the following byte, no `Enable`.
- **Repeated START:** write 0x90, 0x11, repeated START, 0x91 -> `RorW` goes 0 and a read begins; exactly 1 write `Enable` before the restart.
- **Interrupted transfers:** STOP after 4 bits of a write byte -> no `Enable`, IDLE. `Reset` mid-read while `SDA_oe`=1 -> `SDA_oe`=0 the same cycle.
